exec_alu_pipe: RTL and testbench

- Parametrised successor to the 16-bit LC-3 Execute/ALU stage.
- Generalised in data width and in the number of bypass sources. Adds an iterative multiply mode with a busy/stall handshake, a registered condition-code (NZP) output, and a registered address-generation path.
- Sits between Decode/register-file read and Memory stage. Upstream holds its inputs while `busy`=1.

---
 rtl/exec_alu_pipe_if.sv | 43 ++++
 rtl/exec_alu_pipe.sv | 171 +++++++++++++++++
 tb/tb_exec_alu_pipe.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_alu_pipe_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exec_alu_pipe_if : operand/result bundle for exec_alu_pipe          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface exec_alu_pipe_if #(
  parameter int DATA_W  = 16,
  parameter int NUM_BYP = 2,
  parameter int SEL_W   = $clog2(NUM_BYP + 1)
);
  logic                      enable_execute;
  logic                      op_valid;
  logic [2:0]                op_code;
  logic                      use_imm;
  logic [DATA_W-1:0]         src_a;
  logic [DATA_W-1:0]         src_b;
  logic [DATA_W-1:0]         imm;
  logic [DATA_W-1:0]         offset;
  logic [DATA_W-1:0]         npc;
  logic                      base_pc;
  logic [SEL_W-1:0]          byp_sel_a;
  logic [SEL_W-1:0]          byp_sel_b;
  logic [NUM_BYP*DATA_W-1:0] byp_vals;
  logic [DATA_W-1:0]         aluout;
  logic                      res_valid;
  logic                      busy;
  logic [2:0]                nzp;
  logic                      carry;
  logic                      illegal;

  modport master (
    output enable_execute, op_valid, op_code, use_imm, src_a, src_b, imm,
           offset, npc, base_pc, byp_sel_a, byp_sel_b, byp_vals,
    input  aluout, res_valid, busy, nzp, carry, illegal
  );

  modport slave (
    input  enable_execute, op_valid, op_code, use_imm, src_a, src_b, imm,
           offset, npc, base_pc, byp_sel_a, byp_sel_b, byp_vals,
    output aluout, res_valid, busy, nzp, carry, illegal
  );
endinterface
`default_nettype wire

// File: rtl/exec_alu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exec_alu_pipe : parametrised execute/ALU stage with bypass muxes,   |
// | registered NZP and optional iterative multiply (EXEC_ALU_MUL_EN).   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module exec_alu_pipe #(
  parameter int DATA_W  = 16,
  parameter int NUM_BYP = 2,
  parameter int SEL_W   = $clog2(NUM_BYP + 1)
) (
  input wire             clock,
  input wire             reset,
  exec_alu_pipe_if.slave bus
);
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_XNOR = 3'd3;
  localparam logic [2:0] OP_ADDR = 3'd4;

  function automatic logic [2:0] nzp_of(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1])  return 3'b100;
    else if (v == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  logic [DATA_W-1:0] op_a, op_b, op_b_fwd;
  logic [DATA_W:0]   sum_ext, addr_ext;
  logic [DATA_W-1:0] addr_base, alu_res;
  logic              alu_carry, alu_illegal;

  logic [DATA_W-1:0] aluout_q, aluout_d;
  logic              res_valid_q, res_valid_d;
  logic              carry_q, carry_d;
  logic              illegal_q, illegal_d;
  logic [2:0]        nzp_q, nzp_d;

  logic              wr_en, wr_carry, wr_illegal;
  logic [DATA_W-1:0] wr_val;

  // Out-of-range selects fall through to the register-file value.
  always_comb begin
    op_a     = bus.src_a;
    op_b_fwd = bus.src_b;
    for (int k = 1; k <= NUM_BYP; k++) begin
      if (bus.byp_sel_a == SEL_W'(k)) op_a     = bus.byp_vals[(k-1)*DATA_W +: DATA_W];
      if (bus.byp_sel_b == SEL_W'(k)) op_b_fwd = bus.byp_vals[(k-1)*DATA_W +: DATA_W];
    end
    op_b = bus.use_imm ? bus.imm : op_b_fwd;
  end

  always_comb begin
    sum_ext     = {1'b0, op_a} + {1'b0, op_b};
    addr_base   = bus.base_pc ? (bus.npc - DATA_W'(1)) : op_a;
    addr_ext    = {1'b0, addr_base} + {1'b0, bus.offset};
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    case (bus.op_code)
      OP_ADD:  {alu_carry, alu_res} = sum_ext;
      OP_AND:  alu_res = op_a & op_b;
      OP_NOT:  alu_res = ~op_a;
      OP_XNOR: alu_res = ~(op_a ^ op_b);
      OP_ADDR: {alu_carry, alu_res} = addr_ext;
      default: alu_illegal = 1'b1;
    endcase
  end

`ifdef EXEC_ALU_MUL_EN
  localparam int         CNT_W  = $clog2(DATA_W + 1);
  localparam logic [2:0] OP_MUL = 3'd5;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d, partial;
  logic [CNT_W-1:0]  count_q, count_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end

  assign bus.busy = (state_q == ST_MUL);
`else
  assign bus.busy = 1'b0;
`endif

  always_comb begin
    wr_en      = 1'b0;
    wr_val     = alu_res;
    wr_carry   = alu_carry;
    wr_illegal = alu_illegal;
`ifdef EXEC_ALU_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    partial  = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif
    if (bus.enable_execute) begin
`ifdef EXEC_ALU_MUL_EN
      if (state_q == ST_MUL) begin
        // Only the low half is kept, so the multiplicand may shift off the top.
        acc_d    = partial;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d    = ST_IDLE;
          wr_en      = 1'b1;
          wr_val     = partial;
          wr_carry   = 1'b0;
          wr_illegal = 1'b0;
        end
      end else if (bus.op_valid && (bus.op_code == OP_MUL)) begin
        state_d  = ST_MUL;
        mcand_d  = op_a;
        mplier_d = op_b;
        acc_d    = '0;
        count_d  = CNT_W'(DATA_W);
      end else begin
        wr_en = bus.op_valid;
      end
`else
      wr_en = bus.op_valid;
`endif
    end
    aluout_d    = wr_en ? wr_val : aluout_q;
    carry_d     = wr_en ? wr_carry : carry_q;
    nzp_d       = wr_en ? nzp_of(wr_val) : nzp_q;
    illegal_d   = wr_en & wr_illegal;
    res_valid_d = wr_en;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      aluout_q    <= '0;
      res_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      illegal_q   <= 1'b0;
      nzp_q       <= 3'b010;
    end else begin
      aluout_q    <= aluout_d;
      res_valid_q <= res_valid_d;
      carry_q     <= carry_d;
      illegal_q   <= illegal_d;
      nzp_q       <= nzp_d;
    end
  end

  assign bus.aluout    = aluout_q;
  assign bus.res_valid = res_valid_q;
  assign bus.carry     = carry_q;
  assign bus.illegal   = illegal_q;
  assign bus.nzp       = nzp_q;
endmodule
`default_nettype wire

// File: tb/tb_exec_alu_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_exec_alu_pipe : scoreboard bench for exec_alu_pipe               |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_exec_alu_pipe;
  localparam int DATA_W  = 16;
  localparam int NUM_BYP = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;

  exec_alu_pipe_if #(.DATA_W(DATA_W), .NUM_BYP(NUM_BYP)) bus ();

  exec_alu_pipe #(.DATA_W(DATA_W), .NUM_BYP(NUM_BYP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          op;
    logic        use_imm;
    logic [15:0] src_a, src_b, imm, offset, npc;
    logic        base_pc;
    int          sel_a, sel_b;
    logic [31:0] byp;
  } op_t;

  typedef struct packed {
    logic [15:0] val;
    logic        carry;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on the selected operands.
  function automatic int unsigned fwd(input int sel, input logic [15:0] src, input logic [31:0] bv);
    if (sel >= 1 && sel <= NUM_BYP) return 32'(bv[(sel-1)*16 +: 16]);
    return 32'(src);
  endfunction

  function automatic exp_t model(input op_t o);
    int unsigned a, b, r, base;
    exp_t e;
    a = fwd(o.sel_a, o.src_a, o.byp);
    b = o.use_imm ? 32'(o.imm) : fwd(o.sel_b, o.src_b, o.byp);
    e.val = 16'h0; e.carry = 1'b0; e.ill = 1'b0;
    case (o.op)
      0: begin r = a + b; e.val = r[15:0]; e.carry = r[16]; end
      1: e.val = 16'(a & b);
      2: e.val = 16'(~a);
      3: e.val = 16'(~(a ^ b));
      4: begin
        base = o.base_pc ? ((32'(o.npc) + 32'hFFFF) & 32'hFFFF) : a;
        r = base + 32'(o.offset);
        e.val = r[15:0]; e.carry = r[16];
      end
`ifdef EXEC_ALU_MUL_EN
      5: begin r = a * b; e.val = r[15:0]; end
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] exp_nzp(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0)     return 3'b010;
    return 3'b001;
  endfunction

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset && bus.res_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got res_valid with aluout 0x%0h, expected no result", bus.aluout);
      end else begin
        e = exp_q.pop_front();
        check("aluout",  32'(bus.aluout),  32'(e.val));
        check("carry",   32'(bus.carry),   32'(e.carry));
        check("nzp",     32'(bus.nzp),     32'(exp_nzp(e.val)));
        check("illegal", 32'(bus.illegal), 32'(e.ill));
      end
    end
  end

  function automatic op_t nop();
    op_t o;
    o.op = 0; o.use_imm = 1'b0; o.src_a = '0; o.src_b = '0; o.imm = '0;
    o.offset = '0; o.npc = '0; o.base_pc = 1'b0; o.sel_a = 0; o.sel_b = 0; o.byp = '0;
    return o;
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.op = int'($urandom_range(0, 7)); o.use_imm = 1'($urandom_range(0, 1));
    o.src_a = pick16(); o.src_b = pick16(); o.imm = pick16(); o.offset = pick16();
    o.npc = pick16(); o.base_pc = 1'($urandom_range(0, 1));
    o.sel_a = int'($urandom_range(0, 3)); o.sel_b = int'($urandom_range(0, 3));
    o.byp = {pick16(), pick16()};
    return o;
  endfunction

  task automatic apply(input op_t o, input logic valid, input logic en);
    bus.enable_execute = en;
    bus.op_valid  = valid;
    bus.op_code   = 3'(o.op);
    bus.use_imm   = o.use_imm;
    bus.src_a     = o.src_a;
    bus.src_b     = o.src_b;
    bus.imm       = o.imm;
    bus.offset    = o.offset;
    bus.npc       = o.npc;
    bus.base_pc   = o.base_pc;
    bus.byp_sel_a = 2'(o.sel_a);
    bus.byp_sel_b = 2'(o.sel_b);
    bus.byp_vals  = o.byp;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input op_t o);
    apply(o, 1'b1, 1'b1);
    exp_q.push_back(model(o));
    step();
  endtask

  // Counts edges after acceptance until res_valid; enable is dropped for a window.
  task automatic wait_result(input int frz_at, input int frz_len, output int edges, output int busy_n);
    edges = 0;
    busy_n = 0;
    while (edges < 200 && !bus.res_valid) begin
      if (bus.busy) busy_n++;
      bus.enable_execute = !(edges >= frz_at && edges < frz_at + frz_len);
      step();
      edges++;
    end
    bus.enable_execute = 1'b1;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    op_t o, o2;
    int  edges, busy_n, pulses, n;

    apply(nop(), 1'b0, 1'b1);
    step();
    check("rst_aluout",    32'(bus.aluout),    32'h0);
    check("rst_nzp",       32'(bus.nzp),       32'h2);
    check("rst_busy",      32'(bus.busy),      32'h0);
    check("rst_res_valid", 32'(bus.res_valid), 32'h0);
    check("rst_carry",     32'(bus.carry),     32'h0);
    check("rst_illegal",   32'(bus.illegal),   32'h0);
    #2 reset = 1'b1;
    step();

    // ADD with B forwarded from bypass slice 1
    o = nop(); o.op = 0; o.src_a = 16'd5; o.sel_b = 2; o.byp = 32'hFFFF_0000;
    issue(o);
    apply(nop(), 1'b0, 1'b1);
    check("add_pulse_hi", 32'(bus.res_valid), 32'h1);
    step();
    check("add_pulse_lo", 32'(bus.res_valid), 32'h0);

    // Back-to-back ADDR ops, no bubble
    o = nop(); o.op = 4; o.base_pc = 1'b1; o.npc = 16'h3001; o.offset = 16'hFFFE;
    issue(o);
    o = nop(); o.op = 4; o.src_a = 16'h4000; o.offset = 16'h0006;
    issue(o);
    check("addr_b2b_valid", 32'(bus.res_valid), 32'h1);
    apply(nop(), 1'b0, 1'b1);
    step();

    // Reserved op_code 6
    o = nop(); o.op = 6; o.src_a = 16'h1234;
    issue(o);
    check("rsv6_illegal", 32'(bus.illegal), 32'h1);
    check("rsv6_busy",    32'(bus.busy),    32'h0);
    apply(nop(), 1'b0, 1'b1);
    step();

    // Single-cycle op held while frozen
    o = nop(); o.op = 3; o.src_a = 16'h00F0; o.src_b = 16'h0FF0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      apply(o, 1'b1, 1'b0);
      step();
      pulses += int'(bus.res_valid);
    end
    check("freeze_no_pulse", 32'(pulses), 32'h0);
    issue(o);
    apply(nop(), 1'b0, 1'b1);
    step();

`ifdef EXEC_ALU_MUL_EN
    // MUL 3 * 0xFFFE with a second op held during busy
    o = nop(); o.op = 5; o.src_a = 16'h0003; o.src_b = 16'hFFFE;
    issue(o);
    o2 = nop(); o2.op = 0; o2.src_a = 16'h0010; o2.use_imm = 1'b1; o2.imm = 16'h0020;
    apply(o2, 1'b1, 1'b1);
    exp_q.push_back(model(o2));
    wait_result(-1, 0, edges, busy_n);
    check("mul_latency", 32'(edges),  32'd16);
    check("mul_busy_n",  32'(busy_n), 32'd16);
    step();
    check("held_op_valid", 32'(bus.res_valid), 32'h1);
    apply(nop(), 1'b0, 1'b1);
    step();

    // MUL with a 5-cycle freeze
    o = nop(); o.op = 5; o.src_a = 16'h1234; o.src_b = 16'h0005;
    issue(o);
    apply(nop(), 1'b0, 1'b1);
    wait_result(5, 5, edges, busy_n);
    check("mul_freeze_latency", 32'(edges), 32'd21);
    step();

    // Reset in the middle of a multiply
    o = nop(); o.op = 5; o.src_a = 16'h0007; o.src_b = 16'h0009;
    issue(o);
    apply(nop(), 1'b0, 1'b1);
    repeat (5) step();
`else
    o = nop(); o.op = 5; o.src_a = 16'h0003; o.src_b = 16'hFFFE;
    issue(o);
    check("op5_illegal", 32'(bus.illegal), 32'h1);
    check("op5_busy",    32'(bus.busy),    32'h0);
    apply(nop(), 1'b0, 1'b1);
    step();
    o = nop(); o.op = 0; o.src_a = 16'h0001; o.src_b = 16'h0001;
    issue(o);
    o.src_a = 16'h0002;
    apply(o, 1'b1, 1'b1);
`endif
    #2 reset = 1'b0;
    #1;
    check("async_rst_aluout", 32'(bus.aluout),    32'h0);
    check("async_rst_nzp",    32'(bus.nzp),       32'h2);
    check("async_rst_busy",   32'(bus.busy),      32'h0);
    check("async_rst_valid",  32'(bus.res_valid), 32'h0);
    exp_q.delete();
    apply(nop(), 1'b0, 1'b1);
    step();
    step();
    #2 reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      pulses += int'(bus.res_valid);
    end
    check("abort_no_pulse", 32'(pulses), 32'h0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic v, en;
      o  = rand_op();
      v  = ($urandom_range(0, 7) != 0);
      en = ($urandom_range(0, 9) != 0);
      apply(o, v, en);
      if (v && en) exp_q.push_back(model(o));
      step();
`ifdef EXEC_ALU_MUL_EN
      if (v && en && o.op == 5) begin
        n = 0;
        while (n < 200 && !bus.res_valid) begin
          apply(rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          step();
          n++;
        end
        if (n >= 200) begin
          checks++; errors++;
          $display("FAIL rand_mul_timeout: got no result after %0d cycles, expected one", n);
        end
      end
`endif
    end
    apply(nop(), 1'b0, 1'b1);
    repeat (4) step();
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
